instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front-end producer for the single-cycle control path.
- Owns the PC and issues in-order read requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers fetched words in a small FIFO and presents them, with their decoded op/funct3/funct7 fields, to the decode/control stage over a valid/ready handshake.
- Consumes the control stage's PCSrc as a redirect, with its branch/jump target.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction FIFO entries; also the maximum number of outstanding requests (power of two, ≥2).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  word-aligned fetch address.
- imem_rsp_valid  input  1  read data valid; responses return in request order, ≥1 cycle after acceptance.
- imem_rsp_data  input  XLEN  instruction word.
- redirect  input  1  PCSrc from control; one-cycle pulse.
- redirect_target  input  XLEN  new PC when redirect=1.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  decode consumes head.
- instr  output  XLEN  head instruction.
- instr_pc  output  XLEN  PC of head instruction.
- op  output  7  instr[6:0].
- funct3  output  3  instr[14:12].
- funct7  output  1  instr[30].
- misalign_err  output  1  one-cycle pulse: redirect_target[1:0] != 0.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=RUN.
  - All outputs 0 except imem_req_addr=RESET_PC.
- States:
  - RUN: normal fetch.
  - DRAIN: discarding stale responses after a redirect.
- Request issue:
  - imem_req_valid=1 in RUN when (fifo_count + outstanding) < DEPTH and redirect=0.
  - On valid&ready: fetch_pc += 4; outstanding += 1; the PC is pushed to an in-flight PC queue.
  - imem_req_addr/valid are held stable until accepted unless a redirect occurs.
- Response:
  - In RUN, imem_rsp_valid pushes {data, pc} into the FIFO and decrements outstanding.
  - Overflow is impossible by the credit rule.
  - A response with no outstanding request is ignored.
- Output:
  - instr_valid = fifo_count != 0.
  - Pop on instr_valid & instr_ready.
  - op/funct3/funct7 are combinational slices of the head entry; 0 when empty.
- Bypass and latency:
  - No bypass: a response written in cycle N appears on instr_valid in cycle N+1.
  - Simultaneous push and pop is allowed at full FIFO occupancy.
- Redirect (highest priority):
  - Flush the FIFO (instr_valid=0 next cycle).
  - fetch_pc = {redirect_target[XLEN-1:2], 2'b00}.
  - misalign_err pulses the same cycle if redirect_target[1:0] != 0.
  - No request is issued in the redirect cycle.
  - drop_cnt = outstanding - (imem_rsp_valid ? 1 : 0). Any response arriving in the redirect cycle is discarded.
  - Go to DRAIN if drop_cnt > 0, else stay in RUN.
  - A pop in the redirect cycle is still accepted by decode, but the FIFO is then cleared.
- DRAIN:
  - No requests issued.
  - Each imem_rsp_valid decrements drop_cnt and outstanding; data is discarded.
  - When drop_cnt reaches 0, return to RUN; the next request can issue the following cycle.
  - A further redirect in DRAIN overwrites fetch_pc and keeps draining with the recomputed count.
- Wrap-around:
  - fetch_pc wraps modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
  - FIFO and in-flight pointers wrap modulo DEPTH.
- Mid-operation reset: rst_n low at any time returns all state immediately to reset values; in-flight responses after reset release must not be issued by memory (system guarantee).

Test Plan:
- Reset release, memory always ready with 1-cycle latency, instr_ready=1:
  - Requests 0x0, 0x4, 0x8… back-to-back.
  - instr_pc follows the same sequence.
  - op=instr[6:0] for each word (e.g. 0x00500093 → op=0x13, funct3=0).
- Backpressure: instr_ready=0 → after two responses, imem_req_valid stays 0; FIFO holds PCs 0x0, 0x4. Raise instr_ready → fetch resumes at 0x8, no loss or duplication.
- Redirect with two outstanding requests (0x8, 0xC) and target 0x100:
  - FIFO flushed; state=DRAIN; both responses discarded.
  - Next request is 0x100; next delivered instr_pc=0x100.
- Redirect coincident with a response and a pop: the response is dropped, drop_cnt = outstanding - 1, and the popped entry is consumed exactly once.
- Redirect target 0x102 → misalign_err pulses once; fetch resumes at 0x100.
- Assert rst_n=0 mid-DRAIN → outputs clear asynchronously; after release, first request is at RESET_PC.
- PC at 0xFFFF_FFFC → next request address is 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: owns the PC, issues in-order reads to instruction memory
// and buffers returned words in a small FIFO for the decode/control stage.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal fetch; responses are written into the instruction FIFO
// ST_DRAIN | after a redirect; stale responses are counted off and dropped
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic            misalign_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;

  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [AW-1:0]   fifo_wr;
  logic [AW-1:0]   fifo_rd;
  logic [CW-1:0]   fifo_count;

  // PCs of accepted requests, popped in order as responses return
  logic [XLEN-1:0] flight_pc [DEPTH];
  logic [AW-1:0]   flight_wr;
  logic [AW-1:0]   flight_rd;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  logic            req_fire;
  logic            rsp_take;
  logic            push;
  logic            pop;
  logic            credit_ok;
  logic [CW:0]     in_use;
  logic [CW-1:0]   drop_next;
  logic [CW-1:0]   fire_ext;
  logic [CW-1:0]   take_ext;
  logic [CW-1:0]   push_ext;
  logic [CW-1:0]   pop_ext;

  // Credit rule: FIFO entries plus requests in flight never exceed DEPTH
  assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok = in_use < (CW+1)'(DEPTH);

  assign imem_req_valid = rst_n && (state == ST_RUN) && credit_ok && !redirect;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is spurious and is ignored everywhere
  assign rsp_take  = imem_rsp_valid && (outstanding != '0);
  assign push      = rsp_take && (state == ST_RUN) && !redirect;
  assign pop       = instr_valid && instr_ready;

  assign fire_ext  = {{(CW-1){1'b0}}, req_fire};
  assign take_ext  = {{(CW-1){1'b0}}, rsp_take};
  assign push_ext  = {{(CW-1){1'b0}}, push};
  assign pop_ext   = {{(CW-1){1'b0}}, pop};
  assign drop_next = outstanding - take_ext;

  assign misalign_err = rst_n && redirect && (redirect_target[1:0] != 2'b00);

  assign instr_valid = (fifo_count != '0);
  assign instr       = instr_valid ? fifo_data[fifo_rd] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[fifo_rd]   : '0;
  assign op          = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[30];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      fetch_pc    <= RESET_PC;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      fifo_count  <= '0;
      flight_wr   <= '0;
      flight_rd   <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + fire_ext - take_ext;
      if (req_fire) flight_wr <= flight_wr + AW'(1);
      if (rsp_take) flight_rd <= flight_rd + AW'(1);

      if (redirect) begin
        fetch_pc   <= {redirect_target[XLEN-1:2], 2'b00};
        fifo_wr    <= '0;
        fifo_rd    <= '0;
        fifo_count <= '0;
        drop_cnt   <= drop_next;
        state      <= (drop_next != '0) ? ST_DRAIN : ST_RUN;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (push)     fifo_wr  <= fifo_wr + AW'(1);
        if (pop)      fifo_rd  <= fifo_rd + AW'(1);
        fifo_count <= fifo_count + push_ext - pop_ext;

        if (state == ST_DRAIN) begin
          if (rsp_take) drop_cnt <= drop_cnt - CW'(1);
          if ((drop_cnt == '0) || (rsp_take && (drop_cnt == CW'(1)))) begin
            state <= ST_RUN;
          end
        end
      end
    end
  end

  // Storage needs no reset: every read is qualified by the count registers
  always_ff @(posedge clk) begin
    if (req_fire) flight_pc[flight_wr] <= fetch_pc;
    if (push) begin
      fifo_data[fifo_wr] <= imem_rsp_data;
      fifo_pc[fifo_wr]   <= flight_pc[flight_rd];
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: an in-order memory model with hold control,
// a request-address checker and a scoreboard of expected delivered PCs.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic        misalign_err;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_target(redirect_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .op(op), .funct3(funct3), .funct7(funct7),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] sb_pc[$];
  logic [31:0] mq[$];
  logic [31:0] exp_req = 32'h0;
  logic        mem_hold = 1'b0;
  logic        acc = 1'b0;
  logic        rsp_fire = 1'b0;
  logic [31:0] acc_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Hold instr_ready high until exactly n heads have been accepted.
  task automatic consume(input int n);
    int got = 0;
    int budget = 0;
    while (got < n && budget < 300) begin
      instr_ready = 1'b1;
      @(negedge clk);
      if (instr_valid) got++;
      step();
      budget++;
    end
    instr_ready = 1'b0;
    if (got < n) begin
      n_checks++;
      n_err++;
      $display("FAIL consume_timeout: got %0d expected %0d", got, n);
    end
  endtask

  task automatic redir(input logic [31:0] target);
    redirect = 1'b1;
    redirect_target = target;
    @(negedge clk);
    check("misalign_err", {31'b0, misalign_err}, {31'b0, (target[1:0] != 2'b00)});
    check("redirect_no_req", {31'b0, imem_req_valid}, 32'h0);
    step();
    redirect = 1'b0;
    exp_req = {target[31:2], 2'b00};
  endtask

  // Handshake sampling, request-address checking and scoreboard pops on the falling edge.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    logic [31:0] w;
    acc      = rst_n && imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    rsp_fire = rst_n && imem_rsp_valid;
    if (acc) begin
      check("req_addr", imem_req_addr, exp_req);
      exp_req = exp_req + 32'd4;
    end
    if (rst_n && instr_valid && instr_ready) begin
      if (sb_pc.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_instr: got pc %h expected none", instr_pc);
      end else begin
        e = sb_pc.pop_front();
        w = mem_word(e);
        check("instr_pc", instr_pc, e);
        check("instr", instr, w);
        check("op", {25'b0, op}, {25'b0, w[6:0]});
        check("funct3", {29'b0, funct3}, {29'b0, w[14:12]});
        check("funct7", {31'b0, funct7}, {31'b0, w[30]});
      end
    end
  end

  // Memory model: in-order, one cycle minimum latency, responses paused by mem_hold.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mq.delete();
    end else begin
      if (rsp_fire && mq.size() > 0) mq.delete(0);
      if (acc) mq.push_back(acc_addr);
    end
    imem_rsp_valid = rst_n && (mq.size() > 0) && !mem_hold;
    if (imem_rsp_valid) imem_rsp_data = mem_word(mq[0]);
    else imem_rsp_data = 32'h0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_misalign", {31'b0, misalign_err}, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_op", {25'b0, op}, 32'h0);
    step();
    rst_n = 1'b1;

    // Streaming fetch
    for (int i = 0; i < 8; i++) sb_pc.push_back(32'(i * 4));
    consume(8);

    // Backpressure: fetch stalls with the next two words buffered
    repeat (4) step();
    @(negedge clk);
    check("bp_no_req", {31'b0, imem_req_valid}, 32'h0);
    check("bp_instr_valid", {31'b0, instr_valid}, 32'h1);
    check("bp_head_pc", instr_pc, 32'h20);
    step();
    for (int i = 0; i < 4; i++) sb_pc.push_back(32'h20 + 32'(i * 4));
    consume(4);

    // Redirect with two requests outstanding
    repeat (4) step();
    mem_hold = 1'b1;
    sb_pc.push_back(32'h30);
    sb_pc.push_back(32'h34);
    consume(2);
    repeat (3) step();
    @(negedge clk);
    check("credit_stall", {31'b0, imem_req_valid}, 32'h0);
    check("empty_stall", {31'b0, instr_valid}, 32'h0);
    step();
    redir(32'h100);
    mem_hold = 1'b0;
    @(negedge clk);
    check("drain_no_req", {31'b0, imem_req_valid}, 32'h0);
    step();
    sb_pc.push_back(32'h100);
    sb_pc.push_back(32'h104);
    consume(2);

    // Redirect coincident with a response and a pop
    repeat (4) step();
    mem_hold = 1'b1;
    sb_pc.push_back(32'h108);
    consume(1);
    repeat (3) step();
    mem_hold = 1'b0;
    step();
    redirect = 1'b1;
    redirect_target = 32'h200;
    instr_ready = 1'b1;
    sb_pc.push_back(32'h10C);
    @(negedge clk);
    check("coinc_misalign", {31'b0, misalign_err}, 32'h0);
    check("coinc_head_valid", {31'b0, instr_valid}, 32'h1);
    step();
    redirect = 1'b0;
    instr_ready = 1'b0;
    exp_req = 32'h200;
    @(negedge clk);
    check("flushed_after_redirect", {31'b0, instr_valid}, 32'h0);
    step();
    sb_pc.push_back(32'h200);
    consume(1);

    // Misaligned redirect target
    repeat (4) step();
    redir(32'h102);
    @(negedge clk);
    check("misalign_once", {31'b0, misalign_err}, 32'h0);
    step();
    sb_pc.push_back(32'h100);
    consume(1);

    // Reset asserted while draining
    repeat (4) step();
    mem_hold = 1'b1;
    sb_pc.push_back(32'h104);
    sb_pc.push_back(32'h108);
    consume(2);
    repeat (3) step();
    redir(32'h300);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("midrst_req_addr", imem_req_addr, 32'h0);
    check("midrst_instr_valid", {31'b0, instr_valid}, 32'h0);
    check("midrst_op", {25'b0, op}, 32'h0);
    mem_hold = 1'b0;
    exp_req = 32'h0;
    step();
    step();
    rst_n = 1'b1;
    sb_pc.push_back(32'h0);
    consume(1);

    // PC wrap-around
    repeat (4) step();
    redir(32'hFFFF_FFFC);
    sb_pc.push_back(32'hFFFF_FFFC);
    sb_pc.push_back(32'h0000_0000);
    consume(2);

    repeat (4) step();
    check("sb_empty", 32'(sb_pc.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
